motor_sensor_gen: RTL
=====================

# motor_sensor_gen

Synthetic motor sensor source for the fault-simulation bench. It produces periodic `motor_current`, `vibration` and `temperature` samples in the form the averaging/feature-extraction stage consumes. Each sample carries pseudo-random noise. A small request/acknowledge port injects timed fault episodes: overcurrent, bearing vibration, or overheat. It sits upstream of the feature extractor and drives its sensor inputs directly.

## Interface
- `SAMPLE_DIV`, 4: clock cycles per sample tick (≥2).
- `BASE_CURRENT`, 16'd1000: nominal current level.
- `BASE_VIB`, 16'd100: nominal vibration level.
- `BASE_TEMP`, 16'd250: nominal temperature level.
- `FAULT_LEN`, 64: samples per fault episode (≥1, ≤256).
- `NOISE_BITS`, 4: LFSR bits added as noise (1..8).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fault_req`  in  1  fault request; accepted on its rising edge.
- `fault_sel`  in  2  0=abort/normal, 1=overcurrent, 2=bearing, 3=overheat; sampled with the request.
- `fault_ack`  out  1  one-cycle pulse acknowledging an accepted request.
- `motor_current`  out  16  current sample.
- `vibration`  out  16  vibration sample.
- `temperature`  out  16  temperature sample.
- `sample_valid`  out  1  one-cycle strobe; sample outputs change only in this cycle.
- `fault_active`  out  1  high while the mode is not NORMAL.
- `fault_code`  out  2  current mode (0..3).

## Operation
- **Prescaler:** counts 0..SAMPLE_DIV-1 and wraps. A tick is the cycle with count==SAMPLE_DIV-1.
- **Noise source:** 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - It advances once per tick, after its value is used.
  - noise = lfsr[NOISE_BITS-1:0], zero-extended.
- **Modes (FSM):** NORMAL(0), OVERCURRENT(1), BEARING(2), OVERHEAT(3).
- **Request handling:**
  - `fault_req` is registered, and a rising edge (req & ~req_d) accepts the request.
  - Acceptance latches `fault_sel` into pending_sel and sets pending.
  - A later accept before the next tick overwrites pending_sel.
  - `fault_ack` pulses in the cycle after the accepting edge.
- **Mode update, applied at each tick in priority order:**
  - If pending: mode←pending_sel, fault_cnt←0, pending cleared. pending_sel 0 aborts to NORMAL.
  - Else if mode≠NORMAL and fault_cnt==FAULT_LEN-1: mode←NORMAL.
  - Else if mode≠NORMAL: fault_cnt←fault_cnt+1.
- **Sample computation:** the sample registered at a tick uses the post-update mode and fault_cnt. Each episode therefore produces exactly FAULT_LEN fault samples, with fault_cnt running 0..FAULT_LEN-1.
- **Per-mode values** (n = noise):
  - NORMAL: current=BASE_CURRENT+n, vib=BASE_VIB+n, temp=BASE_TEMP.
  - OVERCURRENT: current=(BASE_CURRENT<<1)+n; vib and temp as NORMAL.
  - BEARING: vib=BASE_VIB+n+(fault_cnt[0] ? 16'd400 : 0); current and temp as NORMAL.
  - OVERHEAT: temp=BASE_TEMP+2*fault_cnt; current and vib as NORMAL.
- **Arithmetic:** all sums are computed 18 bits wide and saturate to 16'hFFFF; no wrap-around.
- **Status outputs:** `fault_active` and `fault_code` follow the registered mode. They change only at ticks.

## Timing
- **Reset values:** all sample outputs 0, `sample_valid` 0, `fault_ack` 0, `fault_active` 0, `fault_code` 0.
  - Internal state resets to: mode NORMAL, prescaler 0, fault_cnt 0, pending 0, req_d 0, LFSR 16'hACE1.
- **First tick:** in cycle SAMPLE_DIV-1 after reset deasserts. The first `sample_valid` is visible in cycle SAMPLE_DIV, since outputs are registered.
- **Request-to-fault latency:** the first faulted sample is the first tick strictly after the accepting cycle.
  - An edge accepted in the tick cycle itself is applied at the following tick.
- **Back-to-back ticks:** `sample_valid` is never high on consecutive cycles.
- **Simultaneous events:** if pending and episode expiry fall on the same tick, pending wins.
- **Held request:** a held-high `fault_req` produces exactly one accept and one ack.
- **Reset mid-operation:**
  - Reset mid-episode returns to NORMAL.
  - Reset discards pending and clears the ack.
  - The prescaler restarts, so the next tick is again SAMPLE_DIV-1 cycles after release.

## Test plan
- **Reset and first sample:** defaults; release reset. Required: first `sample_valid` in cycle 4 with current=1001, vib=101, temp=250. Strobes then repeat every 4 cycles.
- **Overheat episode:** pulse `fault_req` with sel=3. Required:
  - `fault_ack` 1 cycle later.
  - The next sample has temp=250, then 252, 254, … up to 376 on the 64th sample.
  - The 65th sample has temp=250 with `fault_active`=0.
- **Bearing fault:** sel=2. Required: vib alternates BASE_VIB+n and BASE_VIB+n+400 (first fault sample has no burst); current and temp stay nominal.
- **Abort and overwrite:** request sel=1, then sel=0 three samples later. Required: current returns to 1000+n at the next tick.
  - Separately, two accepts before one tick (sel=2 then sel=3): only OVERHEAT appears.
- **Saturation:** override BASE_TEMP=16'hFFF0 and FAULT_LEN=16, then request overheat. Required: temp=16'hFFF0, 16'hFFF2, …, holding at 16'hFFFF from fault_cnt 8 onward, with no wrap.
- **Reset mid-episode:** during OVERCURRENT, assert `rst` for 1 cycle. Required: all outputs 0 the next cycle, `fault_code`=0, and the next sample is nominal with LFSR reseeded (current=1001).

Source files
------------

// File: rtl/motor_sensor_gen.sv
// motor_sensor_gen: synthetic motor sensor source for the fault-simulation bench.
// It emits periodic current/vibration/temperature samples with LFSR noise.
// A request/acknowledge port injects timed fault episodes.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   fault_req       fault request, accepted on its rising edge
//   fault_sel[1:0]  0=abort/normal, 1=overcurrent, 2=bearing, 3=overheat
//   fault_ack       one-cycle pulse, the cycle after an accepted request
//   motor_current, vibration, temperature [15:0]  sample outputs
//   sample_valid    one-cycle strobe; sample outputs change only in this cycle
//   fault_active    high while the mode is not NORMAL
//   fault_code[1:0] current mode
module motor_sensor_gen #(
  parameter int unsigned SAMPLE_DIV   = 4,
  parameter logic [15:0] BASE_CURRENT = 16'd1000,
  parameter logic [15:0] BASE_VIB     = 16'd100,
  parameter logic [15:0] BASE_TEMP    = 16'd250,
  parameter int unsigned FAULT_LEN    = 64,
  parameter int unsigned NOISE_BITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fault_req,
  input  logic [1:0]  fault_sel,
  output logic        fault_ack,
  output logic [15:0] motor_current,
  output logic [15:0] vibration,
  output logic [15:0] temperature,
  output logic        sample_valid,
  output logic        fault_active,
  output logic [1:0]  fault_code
);

  localparam logic [1:0] MODE_NORMAL      = 2'd0;
  localparam logic [1:0] MODE_OVERCURRENT = 2'd1;
  localparam logic [1:0] MODE_BEARING     = 2'd2;
  localparam logic [1:0] MODE_OVERHEAT    = 2'd3;

  localparam int unsigned PRE_W     = $clog2(SAMPLE_DIV);
  localparam int unsigned CNT_W     = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [17:0] BURST     = 18'd400;

  logic [PRE_W-1:0] presc;
  logic             tick_c;
  logic [15:0]      lfsr;
  logic             lfsr_fb_c;
  logic             req_d;
  logic             accept_c;
  logic             pending;
  logic [1:0]       pending_sel;
  logic [1:0]       mode, mode_nxt;
  logic [CNT_W-1:0] fault_cnt, cnt_nxt;
  logic [17:0]      noise_c, cur_sum_c, vib_sum_c, temp_sum_c;

  // Clamp an 18-bit sum to the 16-bit output range.
  function automatic logic [15:0] sat16(input logic [17:0] v);
    return (|v[17:16]) ? 16'hFFFF : v[15:0];
  endfunction

  assign tick_c    = (presc == PRE_W'(SAMPLE_DIV - 1));
  assign accept_c  = fault_req & ~req_d;
  assign lfsr_fb_c = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign fault_code = mode;

  // Mode/episode state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode         <= MODE_NORMAL;
      fault_cnt    <= '0;
      fault_active <= 1'b0;
    end else begin
      mode         <= mode_nxt;
      fault_cnt    <= cnt_nxt;
      fault_active <= (mode_nxt != MODE_NORMAL);
    end
  end

  // Mode update at each tick: pending request beats episode expiry.
  always_comb begin
    mode_nxt = mode;
    cnt_nxt  = fault_cnt;
    if (tick_c) begin
      if (pending) begin
        mode_nxt = pending_sel;
        cnt_nxt  = '0;
      end else if ((mode != MODE_NORMAL) && (fault_cnt == CNT_W'(FAULT_LEN - 1))) begin
        mode_nxt = MODE_NORMAL;
        cnt_nxt  = '0;
      end else if (mode != MODE_NORMAL) begin
        cnt_nxt = fault_cnt + CNT_W'(1);
      end
    end
  end

  // Sample values from the post-update mode and the current (pre-advance) LFSR.
  always_comb begin
    noise_c    = 18'(lfsr[NOISE_BITS-1:0]);
    cur_sum_c  = 18'(BASE_CURRENT) + noise_c;
    vib_sum_c  = 18'(BASE_VIB) + noise_c;
    temp_sum_c = 18'(BASE_TEMP);
    case (mode_nxt)
      MODE_OVERCURRENT: cur_sum_c = {1'b0, BASE_CURRENT, 1'b0} + noise_c;
      MODE_BEARING:     if (cnt_nxt[0]) vib_sum_c = 18'(BASE_VIB) + noise_c + BURST;
      MODE_OVERHEAT:    temp_sum_c = 18'(BASE_TEMP) + 18'({cnt_nxt, 1'b0});
      default: ;
    endcase
  end

  // Prescaler, noise source, request capture and registered sample outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc         <= '0;
      lfsr          <= LFSR_SEED;
      req_d         <= 1'b0;
      pending       <= 1'b0;
      pending_sel   <= MODE_NORMAL;
      fault_ack     <= 1'b0;
      sample_valid  <= 1'b0;
      motor_current <= '0;
      vibration     <= '0;
      temperature   <= '0;
    end else begin
      req_d        <= fault_req;
      fault_ack    <= accept_c;
      sample_valid <= tick_c;
      if (tick_c) begin
        presc         <= '0;
        lfsr          <= {lfsr_fb_c, lfsr[15:1]};
        motor_current <= sat16(cur_sum_c);
        vibration     <= sat16(vib_sum_c);
        temperature   <= sat16(temp_sum_c);
      end else begin
        presc <= presc + PRE_W'(1);
      end
      // An accept in the tick cycle survives the clear and applies next tick.
      if (accept_c) begin
        pending     <= 1'b1;
        pending_sel <= fault_sel;
      end else if (tick_c) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
